// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, write-first read bypass,
// 1- or 2-cycle read latency and a one-word-per-cycle clear sweep.
module ram_dp_be #(
    parameter int                   MEM_WIDTH  = 16,
    parameter int                   MEM_DEPTH  = 1024,
    parameter int                   ADDER_SIZE = 10,
    parameter int                   RD_LAT     = 1,
    parameter logic [MEM_WIDTH-1:0] CLR_VAL    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    blk_select,
    input  logic                    wr_en,
    input  logic [MEM_WIDTH/8-1:0]  wr_be,
    input  logic [ADDER_SIZE-1:0]   adde_wr,
    input  logic [MEM_WIDTH-1:0]    din,
    input  logic                    rd_en,
    input  logic [ADDER_SIZE-1:0]   addr_rd,
    output logic [MEM_WIDTH-1:0]    dout,
    output logic                    rd_valid,
    input  logic                    clr_req,
    output logic                    busy
);

    localparam int                    NB        = MEM_WIDTH / 8;
    localparam logic [ADDER_SIZE:0]   DEPTH_L   = (ADDER_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDER_SIZE-1:0] LAST_ADDR = ADDER_SIZE'(MEM_DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  state_reg, state_next;
    logic [ADDER_SIZE-1:0]   clr_addr_reg, clr_addr_next;

    logic [MEM_WIDTH-1:0]    mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0]    mem_rd;
    logic [MEM_WIDTH-1:0]    rd_word;
    logic                    wr_in_range, rd_in_range;
    logic                    wr_acc, rd_acc, wr_hit;
    logic                    pipe_valid;
    logic [MEM_WIDTH-1:0]    pipe_data;
    logic [MEM_WIDTH-1:0]    dout_reg;
    logic                    rd_valid_reg;

    // Clear FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // Clear FSM: next state; clr_req is only looked at in IDLE
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (clr_req) begin
                    state_next    = S_CLEAR;
                    clr_addr_next = '0;
                end
            end
            S_CLEAR: begin
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = S_IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        busy = 1'b0;
        if (state_reg == S_CLEAR) begin
            busy = 1'b1;
        end
    end

    assign wr_in_range = {1'b0, adde_wr} < DEPTH_L;
    assign rd_in_range = {1'b0, addr_rd} < DEPTH_L;
    assign wr_acc      = blk_select & wr_en & ~busy & wr_in_range;
    assign rd_acc      = blk_select & rd_en & ~busy;
    assign wr_hit      = wr_acc & (adde_wr == addr_rd);

    // Array is never reset, so a reset mid-sweep leaves partial progress intact
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr_reg] <= CLR_VAL;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[adde_wr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
        end
    end

    assign mem_rd = mem[addr_rd];

    // Write-first bypass per byte; out-of-range reads return zero
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign rd_word[gi*8 +: 8] = (wr_hit && wr_be[gi]) ? din[gi*8 +: 8] :
                                        (rd_in_range ? mem_rd[gi*8 +: 8] : 8'h00);
        end
    endgenerate

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                 s1_valid_reg;
            logic [MEM_WIDTH-1:0] s1_data_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_reg <= 1'b0;
                    s1_data_reg  <= '0;
                end else begin
                    s1_valid_reg <= rd_acc;
                    if (rd_acc) begin
                        s1_data_reg <= rd_word;
                    end
                end
            end
            assign pipe_valid = s1_valid_reg;
            assign pipe_data  = s1_data_reg;
        end else begin : g_lat1
            assign pipe_valid = rd_acc;
            assign pipe_data  = rd_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg     <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= pipe_valid;
            if (pipe_valid) begin
                dout_reg <= pipe_data;
            end
        end
    end

    assign dout     = dout_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 16, data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter ADDER_SIZE, default 10, address width, with 2**ADDER_SIZE >= MEM_DEPTH.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 or 2.
REQ-005 SHALL have parameter CLR_VAL, default 0, MEM_WIDTH-bit value written by the clear sweep.
REQ-006 SHALL have one clock, clk; reset rst is asynchronous and active-high.
REQ-007 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- blk_select  in  1  block enable; when low, all user reads and writes are ignored
- wr_en  in  1  write request
- wr_be  in  MEM_WIDTH/8  byte enables; bit b controls byte b
- adde_wr  in  ADDER_SIZE  write address
- din  in  MEM_WIDTH  write data
- rd_en  in  1  read request
- addr_rd  in  ADDER_SIZE  read address
- dout  out  MEM_WIDTH  read data, registered
- rd_valid  out  1  dout carries new read data this cycle
- clr_req  in  1  start the clear sweep
- busy  out  1  clear sweep in progress

Function
REQ-008 SHALL commit a write at the rising edge when blk_select & wr_en & !busy, updating only the bytes with wr_be[b]=1; wr_be=0 changes nothing.
REQ-009 SHALL accept a read at the rising edge when blk_select & rd_en & !busy.
- RD_LAT=1: dout is updated at that edge and rd_valid is high for the following cycle.
- RD_LAT=2: one additional pipeline register is inserted; dout and rd_valid appear one cycle later.
REQ-010 SHALL hold dout at its last value when no read completes; rd_valid SHALL be a single-cycle pulse per accepted read, and back-to-back reads SHALL yield one result per cycle.
REQ-011 SHALL resolve a same-cycle read and write to the same address write-first per byte: enabled bytes return din, disabled bytes return the old contents.
REQ-012 SHALL ignore writes to addresses >= MEM_DEPTH; reads of such addresses SHALL return 0 with rd_valid asserted normally.
REQ-013 SHALL implement the clear FSM with states IDLE and CLEAR:
- IDLE->CLEAR on clr_req=1 at an edge, with busy=1 registered at that same edge.
- CLEAR writes CLR_VAL to address 0, then 1, ... MEM_DEPTH-1, one word per cycle.
- CLEAR->IDLE at the edge that writes MEM_DEPTH-1; busy=0 after that edge, so busy is high for exactly MEM_DEPTH cycles.
REQ-014 SHALL ignore clr_req while in CLEAR; it SHALL not restart the sweep.
REQ-015 SHALL, when clr_req and a user write occur in the same IDLE cycle, commit the user write; the sweep then overwrites that word.
REQ-016 SHALL return rd_valid=0 for reads requested while busy=1; with RD_LAT=2, reads already in the pipeline still complete.
REQ-017 SHALL handle blk_select independently of the FSM: blk_select=0 does not pause the sweep.

Reset
REQ-018 SHALL, on rst=1, immediately force dout=0, rd_valid=0, busy=0, the FSM to IDLE, the clear address to 0, and the read pipeline empty.
REQ-019 SHALL NOT reset array contents; a reset during CLEAR aborts the sweep and leaves already-cleared words cleared and all others unchanged.

Verification (MEM_WIDTH=16, MEM_DEPTH=1024, CLR_VAL=0)
REQ-020 SHALL cover the basic write/read path:
- RD_LAT=1: write 0xABCD to address 5 with wr_be=11, then read address 5 -> dout=0xABCD and rd_valid=1 one cycle after the read edge.
- RD_LAT=2: the same sequence -> result appears two cycles after the read edge.
REQ-021 SHALL cover byte enables: with mem[5]=0xABCD, write 0x1234 with wr_be=01, then read -> 0xAB34.
REQ-022 SHALL cover read-during-write: with mem[7]=0x0000, write 0xFFFF with wr_be=10 and read address 7 in the same cycle -> dout=0xFF00.
REQ-023 SHALL cover blk_select=0: with wr_en=1 and rd_en=1 to address 5 -> mem[5] unchanged and rd_valid stays 0.
REQ-024 SHALL cover the clear sweep:
- Pulse clr_req -> busy high for exactly 1024 cycles.
- A read issued during the sweep -> rd_valid=0.
- After busy drops, reads of addresses 0 and 1023 -> 0x0000.
REQ-025 SHALL cover reset mid-clear: preload mem[500]=0x5A5A, start a sweep, and assert rst when the clear address is 100 -> busy=0 and dout=0 immediately, mem[50]=0x0000, mem[500]=0x5A5A.
